// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and the RV32I datapath.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] result_src;
    logic [2:0] alu_ctrl;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
               alu_src_a, alu_src_b, imm_src, result_src, alu_ctrl, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
               alu_src_a, alu_src_b, imm_src, result_src, alu_ctrl, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle controller; 3-5 cycles per instruction with no wait states.
// mem_ready low stretches FETCH, MEMREAD or MEMWRITE by one cycle per wait.
module multicycle_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_if.master    io_ctrl
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t     r_state;
    logic       r_illegal;

    logic       w_f3_unsup;
    logic       w_br_ok;
    logic       w_br_take;
    logic [2:0] w_alu_dec;

    logic       w_mem_req, w_adr_src, w_ir_write, w_pc_write, w_mem_write, w_reg_write;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_imm_src, w_result_src;
    logic [2:0] w_alu_ctrl;

    // Shifts and sltu have no ALU encoding here, so they are trapped as illegal.
    assign w_f3_unsup = (io_ctrl.funct3 == 3'b001) || (io_ctrl.funct3 == 3'b011) ||
                        (io_ctrl.funct3 == 3'b101);
    assign w_br_ok    = (io_ctrl.funct3 == 3'b000) || (io_ctrl.funct3 == 3'b001);
    assign w_br_take  = ((io_ctrl.funct3 == 3'b000) &&  io_ctrl.zero) ||
                        ((io_ctrl.funct3 == 3'b001) && !io_ctrl.zero);

    always_comb begin
        w_alu_dec = ALU_ADD;
        case (io_ctrl.funct3)
            3'b000:  w_alu_dec = (r_state == S_EXECR && io_ctrl.funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_dec = ALU_SLT;
            3'b100:  w_alu_dec = ALU_XOR;
            3'b110:  w_alu_dec = ALU_OR;
            3'b111:  w_alu_dec = ALU_AND;
            default: w_alu_dec = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:    if (io_ctrl.mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (io_ctrl.op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_R:         r_state <= S_EXECR;
                        OP_I:         r_state <= S_EXECI;
                        OP_BR:        r_state <= S_BRANCH;
                        OP_JAL:       r_state <= S_JAL;
                        default: begin
                            r_state   <= S_FETCH;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR:   r_state <= (io_ctrl.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (io_ctrl.mem_ready) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (io_ctrl.mem_ready) r_state <= S_FETCH;
                S_EXECR, S_EXECI: begin
                    if (w_f3_unsup) begin
                        r_state   <= S_FETCH;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state   <= S_ALUWB;
                    end
                end
                S_ALUWB:    r_state <= S_FETCH;
                S_BRANCH: begin
                    r_state <= S_FETCH;
                    if (!w_br_ok) r_illegal <= 1'b1;
                end
                S_JAL:      r_state <= S_ALUWB;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_imm_src    = 2'b00;
        w_result_src = 2'b00;
        w_alu_ctrl   = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = io_ctrl.mem_ready;
                w_pc_write   = io_ctrl.mem_ready;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                w_imm_src   = 2'b10;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_imm_src   = (io_ctrl.op == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                w_alu_src_a = 2'b10;
                w_alu_ctrl  = w_alu_dec;
            end
            S_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_ctrl  = w_alu_dec;
            end
            S_ALUWB:  w_reg_write = 1'b1;
            S_BRANCH: begin
                w_alu_src_a = 2'b10;
                w_alu_ctrl  = ALU_SUB;
                w_pc_write  = w_br_take;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are masked by reset so a mid-instruction reset cannot leak a write.
    assign io_ctrl.mem_req    = w_mem_req;
    assign io_ctrl.adr_src    = w_adr_src;
    assign io_ctrl.ir_write   = w_ir_write  & rst_n;
    assign io_ctrl.pc_write   = w_pc_write  & rst_n;
    assign io_ctrl.mem_write  = w_mem_write & rst_n;
    assign io_ctrl.reg_write  = w_reg_write & rst_n;
    assign io_ctrl.alu_src_a  = w_alu_src_a;
    assign io_ctrl.alu_src_b  = w_alu_src_b;
    assign io_ctrl.imm_src    = w_imm_src;
    assign io_ctrl.result_src = w_result_src;
    assign io_ctrl.alu_ctrl   = w_alu_ctrl;
    assign io_ctrl.illegal    = r_illegal;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and random instructions against a per-instruction
// outcome model (cycle count, enable counts, ALU op, sticky illegal flag).
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic exp_ill  = 1'b0;

    logic [6:0] op_tab [0:6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111, 7'b0110111};

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_ctrl (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] alu_expect(input logic is_r, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (is_r && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd4:    return 3'b100;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Called at a falling edge at the start of a FETCH cycle; returns at the start of the next one.
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int wf, input int wm);
        int e_cyc = 0, e_pc = 1, e_reg = 0, e_mw = 0, e_exec = 0;
        logic [1:0] e_src = 2'b00;
        logic [2:0] e_alu = 3'b000;
        logic e_ill = 1'b0;
        int n_ir = 0, n_pc = 0, n_reg = 0, n_src = 0, n_mw = 0, n_exec = 0;
        logic [2:0] o_alu = 3'bxxx;
        int wfl = wf, wml = wm;
        logic shift = (f3 == 3'd1) || (f3 == 3'd3) || (f3 == 3'd5);

        case (o)
            7'b0000011: begin e_cyc = 5 + wf + wm; e_reg = 1; e_src = 2'b01; e_exec = 1; end
            7'b0100011: begin e_cyc = 4 + wf + wm; e_mw = 1 + wm; e_exec = 1; end
            7'b0110011, 7'b0010011: begin
                e_exec = 1;
                if (shift) begin e_cyc = 3 + wf; e_ill = 1'b1; end
                else begin
                    e_cyc = 4 + wf; e_reg = 1;
                    e_alu = alu_expect(o == 7'b0110011, f3, f7);
                end
            end
            7'b1100011: begin
                e_cyc = 3 + wf; e_exec = 1; e_alu = 3'b001;
                e_pc  = 1 + (((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z) ? 1 : 0);
                e_ill = (f3 > 3'd1);
            end
            7'b1101111: begin e_cyc = 4 + wf; e_pc = 2; e_reg = 1; end
            default:    begin e_cyc = 2 + wf; e_ill = 1'b1; end
        endcase

        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
        for (int c = 0; c < e_cyc; c++) begin
            #1;
            // Memory responder: counts down wait states while a request is open.
            if (bus.mem_req) begin
                if (!bus.adr_src) begin bus.mem_ready = (wfl == 0); if (wfl > 0) wfl--; end
                else              begin bus.mem_ready = (wml == 0); if (wml > 0) wml--; end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            n_ir  += int'(bus.ir_write);
            n_pc  += int'(bus.pc_write);
            n_reg += int'(bus.reg_write);
            n_src += int'(bus.reg_write && bus.result_src == e_src);
            n_mw  += int'(bus.mem_write);
            if (bus.alu_src_a == 2'b10) begin n_exec++; o_alu = bus.alu_ctrl; end
            @(negedge clk);
        end
        exp_ill = exp_ill | e_ill;
        bus.mem_ready = 1'b0;
        #1;
        chk({tag, ".ir_write"},  n_ir,  1);
        chk({tag, ".pc_write"},  n_pc,  e_pc);
        chk({tag, ".reg_write"}, n_reg, e_reg);
        chk({tag, ".wb_src"},    n_src, e_reg);
        chk({tag, ".mem_write"}, n_mw,  e_mw);
        chk({tag, ".exec"},      n_exec, e_exec);
        if (e_exec != 0) chk({tag, ".alu_ctrl"}, o_alu, e_alu);
        chk({tag, ".back_fetch"}, {bus.mem_req, bus.adr_src, bus.alu_src_a, bus.alu_src_b},
            {1'b1, 1'b0, 2'b00, 2'b10});
        chk({tag, ".illegal"}, bus.illegal, exp_ill);
        @(negedge clk);
    endtask

    task automatic pulse_reset(input string tag);
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_ir"},  bus.ir_write, 0);
        chk({tag, ".rst_pc"},  bus.pc_write, 0);
        chk({tag, ".rst_wr"},  {bus.reg_write, bus.mem_write}, 0);
        chk({tag, ".rst_ill"}, bus.illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        exp_ill = 1'b0;
        #1;
        chk({tag, ".post_fetch"},
            {bus.mem_req, bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_ctrl},
            {1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000});
        @(negedge clk);
    endtask

    initial begin
        bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pulse_reset("reset");

        run_instr("sub",     7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);
        run_instr("add_r",   7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr("and_r",   7'b0110011, 3'd7, 1'b0, 1'b0, 1, 0);
        run_instr("or_r",    7'b0110011, 3'd6, 1'b0, 1'b0, 0, 0);
        run_instr("xori",    7'b0010011, 3'd4, 1'b0, 1'b0, 0, 0);
        run_instr("slti",    7'b0010011, 3'd2, 1'b0, 1'b0, 0, 0);
        run_instr("addi_f7", 7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0);
        run_instr("beq_t",   7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);
        run_instr("beq_n",   7'b1100011, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr("bne_t",   7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0);
        run_instr("bne_n",   7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0);
        run_instr("lw",      7'b0000011, 3'd2, 1'b0, 1'b0, 0, 0);
        run_instr("lw_wait", 7'b0000011, 3'd2, 1'b0, 1'b0, 2, 3);
        run_instr("sw_wait", 7'b0100011, 3'd2, 1'b0, 1'b0, 1, 2);
        run_instr("jal",     7'b1101111, 3'd0, 1'b0, 1'b0, 0, 0);

        // Reset while lw waits in MEMREAD.
        bus.op = 7'b0000011; bus.funct3 = 3'd2;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        pulse_reset("mid_rst");

        run_instr("illegal", 7'b0110111, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr("ill_hold1", 7'b0010011, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr("ill_hold2", 7'b0000011, 3'd2, 1'b0, 1'b0, 1, 1);
        pulse_reset("ill_clr");
        run_instr("sll_ill", 7'b0110011, 3'd1, 1'b0, 1'b0, 0, 0);
        pulse_reset("clr2");
        run_instr("blt_ill", 7'b1100011, 3'd4, 1'b0, 1'b1, 0, 0);
        pulse_reset("clr3");

        for (int i = 0; i < 60; i++) begin
            run_instr("rand", op_tab[$urandom_range(0, 6)], 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
